// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and helpers for the VGA framebuffer.
// Holds the fill FSM state encoding and the pixel packing helpers.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    // Number of pixel slots packed into one 32-bit word.
    function automatic int pix_per_word(input int slot_w);
        return 32 / slot_w;
    endfunction

    // Width of the slot-select field at the bottom of a pixel address.
    function automatic int slot_sel_w(input int slot_w);
        return $clog2(32 / slot_w);
    endfunction

    // Copy one zero-extended slot value into every slot of a word.
    function automatic logic [31:0] replicate_pix(input logic [31:0] slot_val, input int slot_w);
        logic [31:0] word;
        case (slot_w)
            8:       word = {4{slot_val[7:0]}};
            16:      word = {2{slot_val[15:0]}};
            default: word = slot_val;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/vga_fb_fill.sv
// vga_fb_fill: hardware fill engine for the VGA framebuffer.
// Writes one full word per cycle over a wrapping word range and
// presents its write port to vga_fb_mem. Only instantiated when
// VGA_FB_FILL_EN is defined.
module vga_fb_fill
    import vga_fb_pkg::*;
#(
    parameter int DEPTH       = 30000,
    parameter int WORD_ADDR_W = 15,
    parameter int PIX_SLOT_W  = 16,
    parameter int PIX_W       = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fill_start,
    input  logic [WORD_ADDR_W-1:0] fill_base,
    input  logic [WORD_ADDR_W-1:0] fill_len,
    input  logic [PIX_W-1:0]       fill_value,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic                   fw_en,
    output logic [WORD_ADDR_W-1:0] fw_addr,
    output logic [31:0]            fw_data
);

    localparam logic [WORD_ADDR_W-1:0] LAST_ADDR = WORD_ADDR_W'(DEPTH - 1);
    localparam logic [WORD_ADDR_W-1:0] ONE_LEFT  = WORD_ADDR_W'(1);

    fill_state_t            state;
    logic [WORD_ADDR_W-1:0] remaining;

    // Fill sequencer: latches the request, walks the range, pulses done.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= FILL_IDLE;
            remaining <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            fw_en     <= 1'b0;
            fw_addr   <= '0;
            fw_data   <= '0;
        end else begin
            case (state)
                FILL_IDLE: begin
                    if (fill_start) begin
                        fill_busy <= 1'b1;
                        if (fill_len != '0) begin
                            state     <= FILL_RUN;
                            remaining <= fill_len;
                            fw_en     <= 1'b1;
                            fw_addr   <= fill_base;
                            fw_data   <= replicate_pix(32'(fill_value), PIX_SLOT_W);
                        end else begin
                            state     <= FILL_DONE;
                            fill_done <= 1'b1;
                        end
                    end
                end
                FILL_RUN: begin
                    if (remaining == ONE_LEFT) begin
                        state     <= FILL_DONE;
                        fw_en     <= 1'b0;
                        fill_done <= 1'b1;
                    end else begin
                        remaining <= remaining - 1'b1;
                        fw_addr   <= (fw_addr == LAST_ADDR) ? '0 : fw_addr + 1'b1;
                    end
                end
                FILL_DONE: begin
                    state     <= FILL_IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
                default: begin
                    state     <= FILL_IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                    fw_en     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_mem.sv
// vga_fb_mem: single-clock VGA framebuffer.
// Byte-enabled 32-bit CPU write port, 2-cycle pipelined pixel read port,
// simple dual-port RAM. Define VGA_FB_FILL_EN to include the hardware
// fill engine; otherwise the fill ports are inert.
module vga_fb_mem
    import vga_fb_pkg::*;
#(
    parameter int DEPTH       = 30000,
    parameter int WORD_ADDR_W = 15,
    parameter int PIX_SLOT_W  = 16,
    parameter int PIX_W       = 12,
    parameter int PIX_ADDR_W  = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   w_en,
    input  logic [WORD_ADDR_W-1:0] w_addr,
    input  logic [3:0]             w_be,
    input  logic [31:0]            w_data,
    output logic                   w_ready,
    input  logic                   r_req,
    input  logic [PIX_ADDR_W-1:0]  r_pix_addr,
    output logic                   r_valid,
    output logic [PIX_W-1:0]       r_pix,
    input  logic                   fill_start,
    input  logic [WORD_ADDR_W-1:0] fill_base,
    input  logic [WORD_ADDR_W-1:0] fill_len,
    input  logic [PIX_W-1:0]       fill_value,
    output logic                   fill_busy,
    output logic                   fill_done
);

    localparam int SEL_W = slot_sel_w(PIX_SLOT_W);
    // One extra bit so DEPTH itself is representable in compares.
    localparam logic [WORD_ADDR_W:0] DEPTH_X = (WORD_ADDR_W + 1)'(DEPTH);

    logic [31:0]            mem [DEPTH];

    logic                   fw_en;
    logic [WORD_ADDR_W-1:0] fw_addr;
    logic [31:0]            fw_data;

    logic                   wr_en;
    logic [WORD_ADDR_W-1:0] wr_addr;
    logic [3:0]             wr_be;
    logic [31:0]            wr_data;
    logic                   wr_ok;

    logic [WORD_ADDR_W-1:0] rd_word_idx;
    logic [1:0]             rd_slot;
    logic [31:0]            rd_word;
    logic                   rd_valid1;
    logic [1:0]             rd_slot1;
    logic                   rd_oob1;
    logic [PIX_W-1:0]       slot_pix;

`ifdef VGA_FB_FILL_EN
    vga_fb_fill #(
        .DEPTH       (DEPTH),
        .WORD_ADDR_W (WORD_ADDR_W),
        .PIX_SLOT_W  (PIX_SLOT_W),
        .PIX_W       (PIX_W)
    ) u_fill (
        .clk        (clk),
        .resetn     (resetn),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fw_en      (fw_en),
        .fw_addr    (fw_addr),
        .fw_data    (fw_data)
    );
`else
    assign fill_busy = 1'b0;
    assign fill_done = 1'b0;
    assign fw_en     = 1'b0;
    assign fw_addr   = '0;
    assign fw_data   = '0;

    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_base, fill_len, fill_value};
`endif

    // CPU writes are held off for the whole fill, including its done cycle.
    assign w_ready = ~fill_busy;

    // Write-side mux: the fill engine owns the RAM write port while it runs.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = w_addr;
        wr_be   = w_be;
        wr_data = w_data;
        if (fw_en) begin
            wr_en   = 1'b1;
            wr_addr = fw_addr;
            wr_be   = 4'hF;
            wr_data = fw_data;
        end else begin
            wr_en   = w_en & w_ready;
        end
    end

    // Writes beyond the framebuffer are dropped silently.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_X);

    // Split the pixel address into word index and slot index.
    assign rd_word_idx = r_pix_addr[PIX_ADDR_W-1:SEL_W];
    if (SEL_W > 0) begin : g_slot
        assign rd_slot = 2'(r_pix_addr[SEL_W-1:0]);
    end else begin : g_no_slot
        assign rd_slot = 2'd0;
    end

    // RAM array with byte-lane writes and a registered read; a same-cycle
    // read of the word being written returns the old contents.
    // NOTE: no reset on the array or its read register, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
        if (r_req) rd_word <= mem[rd_word_idx];
    end

    // Pick the requested slot out of the registered word.
    assign slot_pix = PIX_W'(rd_word >> (32'(rd_slot1) * PIX_SLOT_W));

    // Read pipeline control: stage 1 tracks the RAM access, stage 2 drives the outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid1 <= 1'b0;
            rd_slot1  <= 2'd0;
            rd_oob1   <= 1'b0;
            r_valid   <= 1'b0;
            r_pix     <= '0;
        end else begin
            rd_valid1 <= r_req;
            if (r_req) begin
                rd_slot1 <= rd_slot;
                rd_oob1  <= ({1'b0, rd_word_idx} >= DEPTH_X);
            end
            r_valid <= rd_valid1;
            if (rd_valid1) r_pix <= rd_oob1 ? '0 : slot_pix;
        end
    end

endmodule

// File: tb/tb_vga_fb_mem.sv
// tb_vga_fb_mem: self-checking bench for vga_fb_mem (16-bit slots, 12-bit pixels).
// Directed vector table, randomized traffic against a word-array model,
// and fill-engine sequences (disabled-engine checks without VGA_FB_FILL_EN).
module tb_vga_fb_mem;

    localparam int DEPTH       = 30000;
    localparam int WORD_ADDR_W = 15;
    localparam int PIX_SLOT_W  = 16;
    localparam int PIX_W       = 12;
    localparam int PIX_ADDR_W  = 16;
    localparam int NR          = 400;
    localparam int NV          = 21;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   w_en;
    logic [WORD_ADDR_W-1:0] w_addr;
    logic [3:0]             w_be;
    logic [31:0]            w_data;
    logic                   w_ready;
    logic                   r_req;
    logic [PIX_ADDR_W-1:0]  r_pix_addr;
    logic                   r_valid;
    logic [PIX_W-1:0]       r_pix;
    logic                   fill_start;
    logic [WORD_ADDR_W-1:0] fill_base;
    logic [WORD_ADDR_W-1:0] fill_len;
    logic [PIX_W-1:0]       fill_value;
    logic                   fill_busy;
    logic                   fill_done;

    always #5 clk = ~clk;

    vga_fb_mem #(
        .DEPTH       (DEPTH),
        .WORD_ADDR_W (WORD_ADDR_W),
        .PIX_SLOT_W  (PIX_SLOT_W),
        .PIX_W       (PIX_W),
        .PIX_ADDR_W  (PIX_ADDR_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_be       (w_be),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .r_req      (r_req),
        .r_pix_addr (r_pix_addr),
        .r_valid    (r_valid),
        .r_pix      (r_pix),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    typedef struct {
        logic        we;
        logic [14:0] wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rq;
        logic [15:0] ra;
        logic        ev;
        logic [11:0] ep;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    vec_t        vecs [NV];
    logic [31:0] model [64];
    logic        rnd_ev [NR];
    logic [11:0] rnd_ep [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int a, input logic [3:0] be, input logic [31:0] d);
        w_en = 1'b1; w_addr = 15'(a); w_be = be; w_data = d;
        step();
        w_en = 1'b0;
    endtask

    // Single read: request now, result is visible two edges later.
    task automatic expect_pix(input string name, input int pa, input logic [11:0] exp);
        r_req = 1'b1; r_pix_addr = 16'(pa);
        step();
        r_req = 1'b0;
        step();
        check({name, "_valid"}, r_valid, 1'b1);
        check(name, r_pix, exp);
    endtask

    // Both 16-bit slots of a word, low 12 bits of each.
    task automatic expect_word(input string name, input int w, input logic [31:0] word);
        expect_pix({name, "_s0"}, 2 * w,     word[11:0]);
        expect_pix({name, "_s1"}, 2 * w + 1, word[27:16]);
    endtask

    function automatic vec_t mk(input logic we, input int wa, input logic [3:0] be, input logic [31:0] wd,
                                input logic rq, input int ra, input logic ev, input logic [11:0] ep);
        vec_t v;
        v.we = we; v.wa = 15'(wa); v.be = be; v.wd = wd;
        v.rq = rq; v.ra = 16'(ra); v.ev = ev; v.ep = ep;
        return v;
    endfunction

    // Reference pixel lookup straight from the packing rule.
    function automatic logic [11:0] model_pix(input int pa);
        int w;
        w = pa / 2;
        if (w >= DEPTH) return 12'h000;
        return 12'((model[w] >> ((pa % 2) * 16)) & 32'hFFF);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        w_en = 1'b0; w_addr = '0; w_be = '0; w_data = '0;
        r_req = 1'b0; r_pix_addr = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_r_valid",   r_valid,   1'b0);
        check("rst_r_pix",     r_pix,     12'h000);
        check("rst_w_ready",   w_ready,   1'b1);
        check("rst_fill_busy", fill_busy, 1'b0);
        check("rst_fill_done", fill_done, 1'b0);
        resetn = 1'b1;
        step();
        step();

        // ---------------- directed vector table ----------------
        // Expected outputs in row i come from the read issued in row i-2.
        vecs[0]  = mk(1, 5,     4'hF, 32'hABCD1234, 0, 0,     0, 12'h000);
        vecs[1]  = mk(0, 0,     4'h0, 32'h0,        1, 10,    0, 12'h000);
        vecs[2]  = mk(0, 0,     4'h0, 32'h0,        1, 11,    0, 12'h000);
        vecs[3]  = mk(0, 0,     4'h0, 32'h0,        0, 0,     1, 12'h234);
        vecs[4]  = mk(1, 7,     4'hF, 32'hFFFFFFFF, 0, 0,     1, 12'hBCD);
        vecs[5]  = mk(1, 7,     4'h2, 32'h00000000, 0, 0,     0, 12'h000);
        vecs[6]  = mk(0, 0,     4'h0, 32'h0,        1, 14,    0, 12'h000);
        vecs[7]  = mk(1, 5,     4'hF, 32'h11112222, 1, 10,    0, 12'h000);
        vecs[8]  = mk(0, 0,     4'h0, 32'h0,        1, 10,    1, 12'h0FF);
        vecs[9]  = mk(0, 0,     4'h0, 32'h0,        0, 0,     1, 12'h234);
        vecs[10] = mk(0, 0,     4'h0, 32'h0,        1, 11,    1, 12'h222);
        vecs[11] = mk(0, 0,     4'h0, 32'h0,        1, 60000, 0, 12'h000);
        vecs[12] = mk(0, 0,     4'h0, 32'h0,        1, 10,    1, 12'h111);
        vecs[13] = mk(1, 32767, 4'hF, 32'hFFFFFFFF, 0, 0,     1, 12'h000);
        vecs[14] = mk(0, 0,     4'h0, 32'h0,        1, 11,    1, 12'h222);
        vecs[15] = mk(1, 29999, 4'hF, 32'h0ABC0DEF, 0, 0,     0, 12'h000);
        vecs[16] = mk(0, 0,     4'h0, 32'h0,        1, 59998, 1, 12'h111);
        vecs[17] = mk(0, 0,     4'h0, 32'h0,        1, 59999, 0, 12'h000);
        vecs[18] = mk(0, 0,     4'h0, 32'h0,        0, 0,     1, 12'hDEF);
        vecs[19] = mk(0, 0,     4'h0, 32'h0,        0, 0,     1, 12'hABC);
        vecs[20] = mk(0, 0,     4'h0, 32'h0,        0, 0,     0, 12'h000);

        for (int i = 0; i < NV; i++) begin
            check($sformatf("vec%0d_valid", i), r_valid, vecs[i].ev);
            if (vecs[i].ev) check($sformatf("vec%0d_pix", i), r_pix, vecs[i].ep);
            w_en = vecs[i].we; w_addr = vecs[i].wa; w_be = vecs[i].be; w_data = vecs[i].wd;
            r_req = vecs[i].rq; r_pix_addr = vecs[i].ra;
            step();
        end
        w_en = 1'b0; r_req = 1'b0;
        step();
        step();

        // ---------------- randomized traffic vs model ----------------
        for (int w = 0; w < 64; w++) begin
            model[w] = $urandom;
            cpu_write(w, 4'hF, model[w]);
        end
        step();
        step();
        for (int i = 0; i < NR + 2; i++) begin
            if (i >= 2) begin
                check("rnd_valid", r_valid, rnd_ev[i-2]);
                if (rnd_ev[i-2]) check("rnd_pix", r_pix, rnd_ep[i-2]);
            end
            if (i < NR) begin
                int          ra;
                int          wa;
                logic [3:0]  be;
                logic [31:0] wd;
                logic        we;
                logic        rq;
                rq = ($urandom_range(0, 9) < 6);
                ra = ($urandom_range(0, 15) == 0) ? 2 * DEPTH + int'($urandom_range(0, 100))
                                                  : int'($urandom_range(0, 127));
                we = ($urandom_range(0, 1) == 1);
                wa = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 2000))
                                                 : int'($urandom_range(0, 63));
                be = 4'($urandom);
                wd = $urandom;
                // Read sees the word as it was before this cycle's write.
                rnd_ev[i] = rq;
                rnd_ep[i] = model_pix(ra);
                if (we && wa < 64) begin
                    for (int k = 0; k < 4; k++) if (be[k]) model[wa][8*k +: 8] = wd[8*k +: 8];
                end
                w_en = we; w_addr = 15'(wa); w_be = be; w_data = wd;
                r_req = rq; r_pix_addr = 16'(ra);
            end else begin
                w_en = 1'b0; r_req = 1'b0;
            end
            step();
        end
        w_en = 1'b0; r_req = 1'b0;

`ifdef VGA_FB_FILL_EN
        // ---------------- fill with wrap, CPU write and restart ignored ----------------
        cpu_write(DEPTH - 2, 4'hF, 32'hDEADBEEF);
        cpu_write(DEPTH - 1, 4'hF, 32'hDEADBEEF);
        cpu_write(0,         4'hF, 32'hDEADBEEF);
        cpu_write(1,         4'hF, 32'hDEADBEEF);
        cpu_write(2,         4'hF, 32'hDEADBEEF);
        cpu_write(50,        4'hF, 32'hDEADBEEF);
        fill_start = 1'b1; fill_base = 15'(DEPTH - 2); fill_len = 15'd4; fill_value = 12'h5A5;
        step();
        fill_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("fill_busy_c%0d", k), fill_busy, (k <= 5));
            check($sformatf("fill_done_c%0d", k), fill_done, (k == 5));
            check($sformatf("fill_wready_c%0d", k), w_ready, (k > 5));
            w_en = (k == 2 || k == 3); w_addr = 15'd2; w_be = 4'hF; w_data = 32'hFFFFFFFF;
            fill_start = (k == 3); fill_base = 15'd50; fill_len = 15'd1; fill_value = 12'h111;
            step();
        end
        w_en = 1'b0; fill_start = 1'b0;
        expect_word("fill_dm2", DEPTH - 2, 32'h05A505A5);
        expect_word("fill_dm1", DEPTH - 1, 32'h05A505A5);
        expect_word("fill_w0",  0,         32'h05A505A5);
        expect_word("fill_w1",  1,         32'h05A505A5);
        expect_word("fill_w2",  2,         32'hDEADBEEF);
        expect_word("fill_w50", 50,        32'hDEADBEEF);

        // ---------------- zero-length fill ----------------
        fill_start = 1'b1; fill_base = 15'd2; fill_len = 15'd0; fill_value = 12'hFFF;
        step();
        fill_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("len0_busy_c%0d", k), fill_busy, (k == 1));
            check($sformatf("len0_done_c%0d", k), fill_done, (k == 1));
            check($sformatf("len0_wready_c%0d", k), w_ready, (k != 1));
            step();
        end
        expect_word("len0_w2", 2, 32'hDEADBEEF);

        // ---------------- reset during fill ----------------
        for (int w = 100; w < 106; w++) cpu_write(w, 4'hF, 32'hCAFEF00D);
        fill_start = 1'b1; fill_base = 15'd100; fill_len = 15'd6; fill_value = 12'h3C3;
        step();
        fill_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("abort_busy_c%0d", k), fill_busy, 1'b1);
            if (k < 4) step();
        end
        resetn = 1'b0;
        #1;
        check("abort_busy_rst",   fill_busy, 1'b0);
        check("abort_done_rst",   fill_done, 1'b0);
        check("abort_wready_rst", w_ready,   1'b1);
        step();
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("abort_nodone_c%0d", k), fill_done, 1'b0);
            check($sformatf("abort_idle_c%0d", k), fill_busy, 1'b0);
        end
        expect_word("abort_w100", 100, 32'h03C303C3);
        expect_word("abort_w101", 101, 32'h03C303C3);
        expect_word("abort_w102", 102, 32'h03C303C3);
        expect_word("abort_w103", 103, 32'hCAFEF00D);
        expect_word("abort_w104", 104, 32'hCAFEF00D);
        expect_word("abort_w105", 105, 32'hCAFEF00D);
`else
        // ---------------- fill engine absent: fill_start has no effect ----------------
        cpu_write(200, 4'hF, 32'h12345678);
        fill_start = 1'b1; fill_base = 15'd200; fill_len = 15'd4; fill_value = 12'hFFF;
        step();
        fill_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("nofill_busy_c%0d", k), fill_busy, 1'b0);
            check($sformatf("nofill_done_c%0d", k), fill_done, 1'b0);
            check($sformatf("nofill_wready_c%0d", k), w_ready, 1'b1);
            step();
        end
        expect_word("nofill_w200", 200, 32'h12345678);
        cpu_write(201, 4'hF, 32'h0FED0CBA);
        expect_word("nofill_w201", 201, 32'h0FED0CBA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
